// File: rtl/spi_master_mode.sv
// SPI master: frames words from a ready/consume source onto one of 2**SW chip selects, back-to-back when more words wait.
// Define SPI_MASTER_MODE_CPHA_EN to honour the cpha input; otherwise cpha is ignored and behaves as 0.
module spi_master_mode #(
   parameter int W  = 8,
   parameter int SW = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              step,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [SW-1:0]     sel,
   input  logic [W-1:0]      in,
   output logic              get,
   input  logic              empty,
   output logic [W-1:0]      out,
   output logic              put,
   output logic [2**SW-1:0]  spi_cs_n,
   output logic              spi_clock,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int NCS = 2 ** SW;
   localparam int CW  = $clog2(2 * W + 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t        state;
   logic [W-1:0]  tx_sr;
   logic [W-1:0]  rx_sr;
   logic [CW-1:0] edge_cnt;
   logic          mode_cpol;
   logic          mode_cpha;
   logic          cpha_in;
   logic [CW-1:0] edge_nxt;
   logic          odd_edge;
   logic          last_edge;
   logic          sample_now;
   logic [W-1:0]  rx_shifted;

`ifdef SPI_MASTER_MODE_CPHA_EN
   assign cpha_in = cpha;
`else
   assign cpha_in = cpha & 1'b0;
`endif

   function automatic logic [NCS-1:0] cs_decode(input logic [SW-1:0] s);
      logic [NCS-1:0] cs;
      cs    = '1;
      cs[s] = 1'b0;
      return cs;
   endfunction

   // Edges are numbered from 1; odd edges lead, even edges trail.
   assign edge_nxt   = edge_cnt + CW'(1);
   assign odd_edge   = edge_nxt[0];
   assign last_edge  = (edge_nxt == CW'(2 * W));
   assign sample_now = mode_cpha ? ~odd_edge : odd_edge;
   assign rx_shifted = {rx_sr[W-2:0], spi_miso};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         spi_cs_n  <= '1;
         spi_clock <= 1'b0;
         spi_mosi  <= 1'b0;
         get       <= 1'b0;
         put       <= 1'b0;
         out       <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         edge_cnt  <= '0;
         mode_cpol <= 1'b0;
         mode_cpha <= 1'b0;
      end else begin
         get <= 1'b0;
         put <= 1'b0;
         case (state)
            IDLE: begin
               spi_cs_n  <= '1;
               spi_clock <= cpol;
               spi_mosi  <= 1'b0;
               edge_cnt  <= '0;
               if (step && !empty) begin
                  get       <= 1'b1;
                  mode_cpol <= cpol;
                  mode_cpha <= cpha_in;
                  spi_cs_n  <= cs_decode(sel);
                  rx_sr     <= '0;
                  // Leading-edge sampling needs the MSB on the wire before the first edge.
                  if (!cpha_in) begin
                     spi_mosi <= in[W-1];
                     tx_sr    <= {in[W-2:0], 1'b0};
                  end else begin
                     tx_sr    <= in;
                  end
                  state <= SETUP;
               end
            end
            SETUP: begin
               if (step) begin
                  spi_clock <= mode_cpol;
                  edge_cnt  <= '0;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (step) begin
                  spi_clock <= ~spi_clock;
                  edge_cnt  <= edge_nxt;
                  if (sample_now) begin
                     rx_sr <= rx_shifted;
                  end else if (!last_edge) begin
                     spi_mosi <= tx_sr[W-1];
                     tx_sr    <= {tx_sr[W-2:0], 1'b0};
                  end
                  if (last_edge) begin
                     put      <= 1'b1;
                     out      <= sample_now ? rx_shifted : rx_sr;
                     edge_cnt <= '0;
                     // Chain the next word without releasing chip select.
                     if (!empty) begin
                        get <= 1'b1;
                        if (!mode_cpha) begin
                           spi_mosi <= in[W-1];
                           tx_sr    <= {in[W-2:0], 1'b0};
                        end else begin
                           tx_sr    <= in;
                        end
                     end else begin
                        state <= HOLD;
                     end
                  end
               end
            end
            HOLD: begin
               if (step) begin
                  spi_cs_n <= '1;
                  spi_mosi <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
